// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial WIDTH-bit adder. The operands and the carry-in are accepted
// through a valid/ready handshake. The operands are then shifted LSB-first
// through two cascaded half-adder slices, one bit per clock. The only carry
// path between bits is a single carry flop. When the word is complete, the
// sum and carry-out are offered through a second valid/ready handshake. The
// result is held for as long as the consumer applies backpressure.
//
// Timing: handshake in cycle T, RUN in cycles T+1..T+WIDTH, and out_valid
// high from cycle T+WIDTH+1. The next accept is possible in the cycle after
// the result handoff, which gives one add every WIDTH+2 cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   a, b and cin are valid this cycle
//   in_ready   operands can be accepted (high only in IDLE)
//   a, b       WIDTH-bit operands
//   cin        carry-in for bit 0
//   out_valid  s and c hold a completed result
//   out_ready  consumer accepts the result
//   s          sum, a+b+cin modulo 2^WIDTH
//   c          carry-out of bit WIDTH-1
//   busy       an operation is in progress or its result is pending
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic p, g1, sbit, g2, carry_next, last_bit;

  // Two half-adder slices. The carry between bit positions goes only
  // through the carry flop, so no combinational ripple crosses bits.
  assign p          = a_sh[0] ^ b_sh[0];
  assign g1         = a_sh[0] & b_sh[0];
  assign sbit       = p ^ carry;
  assign g2         = p & carry;
  assign carry_next = g1 | g2;
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // State register.
  // NOTE: sequential state is written only with non-blocking assignments,
  // so every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment comes first, so every path drives
  // state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath.
  // NOTE: every datapath register, including the shift registers, is
  // cleared by reset, so that an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      c         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {sbit, sum_sh[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // The sum register and the final bit are committed together
            // on this edge.
            s         <= {sbit, sum_sh[WIDTH-1:1]};
            c         <= carry_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // s and c are deliberately left alone. They stay valid after the
          // handoff until the next result overwrites them.
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
